stopwatch_display_mux: RTL
==========================

// Module: stopwatch_display_mux
// PURPOSE
//   Reads the MM:SS BCD digit outputs of the stopwatch counter and drives a
//   4-digit common-anode 7-segment display, one digit at a time.
//   Latches a digit snapshot once per scan so a counter update never shows
//   a mixed frame. Blinks the field being adjusted while adj is high.
//   Sits between the stopwatch counter and the board display pins.
// PARAMETERS
//   REFRESH_DIV  100000  clock cycles per digit slot; must be >= 2
//   BLINK_DIV    25000000  clock cycles per blink half-period; must be >= 2
// PORTS
//   clock     in   1  system clock; all logic on its rising edge
//   rst       in   1  synchronous reset, active-high
//   min_ten   in   4  BCD minutes tens digit
//   min_unit  in   4  BCD minutes units digit
//   sec_ten   in   3  BCD seconds tens digit, 0..5
//   sec_unit  in   4  BCD seconds units digit
//   adj       in   1  adjust mode; enables blinking of the selected field
//   sel       in   1  field under adjust: 0 = seconds, 1 = minutes
//   an        out  4  digit enables, active-low; an[0] = rightmost digit
//   seg       out  7  segments, active-low, bit order {g,f,e,d,c,b,a}
//   dp        out  1  decimal point, active-low
// BEHAVIOUR
// - Reset (rst high at the clock edge) sets an=4'b1111, seg=7'h7F, dp=1,
//   digit index=0, refresh count=0, blink count=0, blink_phase=0, and all
//   snapshot digits=0. Reset has priority over every other event.
// - Refresh: the count runs 0..REFRESH_DIV-1. At the terminal value it wraps
//   to 0, and the index advances 0->1->2->3->0.
// - Digit map: idx0=sec_unit, idx1=sec_ten (zero-extended to 4 bits),
//   idx2=min_unit, idx3=min_ten.
// - Snapshot: all four inputs are captured in the same cycle the index wraps
//   3->0. No other cycle captures them. The display shows only snapshot values.
// - Outputs are registered. an, seg and dp reflect the index held in cycle N
//   at cycle N+1, so latency is 1 cycle. Exactly one an bit is low, except
//   when the digit is blanked or the block is in reset.
// - Decode: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001,
//   5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
//   Codes 10..15 show a dash, 0111111.
// - dp=0 only when idx=2 (MM.SS separator); otherwise dp=1.
// - Blink: while adj=1, the blink count runs 0..BLINK_DIV-1 and blink_phase
//   toggles at each wrap. While adj=0, the count and blink_phase are held at 0.
// - Blanking: when adj=1 and blink_phase=1, the digits of the selected field
//   are blanked: sel=0 blanks idx0 and idx1, sel=1 blanks idx2 and idx3.
//   A blanked slot drives an=4'b1111, seg=7'h7F, dp=1. The scan timing does
//   not change.
// - A change of sel takes effect on the next output update. A change of adj
//   takes effect in the next cycle and never stalls the scan.
// - Reset mid-scan: outputs return to their reset values on that edge. After
//   rst falls, the scan restarts at idx0, showing the zero snapshot until the
//   first wrap 3->0.
// TESTING
//   (Benches use REFRESH_DIV=4, BLINK_DIV=16.)
//   1. Reset, then hold inputs 1,2,3,4 (MM=12, SS=34). After the first wrap,
//      the scan repeats an=1110/1101/1011/0111 for 4 cycles each, with
//      seg=0011001 (4), 0110000 (3), 0100100 (2) with dp=0, and 1111001 (1).
//   2. Change sec_unit from 4 to 5 while idx=1. The idx0 slot shows 4 until
//      the 3->0 wrap and 5 (0010010) afterwards, with no mixed frame.
//   3. Set min_ten=4'hC. The idx3 slot shows seg=0111111. Every other digit
//      is unaffected.
//   4. Set adj=1, sel=1. Digits 2 and 3 alternate visible/blank every 16
//      cycles (an stays 1111 in their slots). Digits 0 and 1 stay visible.
//      Drop adj: all digits are visible at the next update.
//   5. Set adj=1, sel=0. Digits 0 and 1 blink. Switch sel to 1 mid-blank:
//      blanking moves to digits 2 and 3 at the next update.
//   6. Assert rst for 1 cycle with idx=2 and adj=1. Next cycle an=1111,
//      seg=7F, dp=1. The scan then restarts at an=1110 showing 0 (1000000).

Source files
------------

// File: rtl/stopwatch_display_mux.sv
// Multiplexes the stopwatch MM:SS BCD digits onto a 4-digit common-anode
// 7-segment display, with a per-scan digit snapshot and blinking of the adjusted field.
module stopwatch_display_mux #(
    parameter int REFRESH_DIV = 100000,
    parameter int BLINK_DIV   = 25000000
) (
    input  logic       clock,
    input  logic       rst,
    input  logic [3:0] min_ten,
    input  logic [3:0] min_unit,
    input  logic [2:0] sec_ten,
    input  logic [3:0] sec_unit,
    input  logic       adj,
    input  logic       sel,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int RW = $clog2(REFRESH_DIV);
    localparam int BW = $clog2(BLINK_DIV);
    localparam logic [RW-1:0] REF_TOP   = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_TOP = BW'(BLINK_DIV - 1);

    logic [RW-1:0] r_ref_cnt;
    logic [1:0]    r_idx;
    logic [BW-1:0] r_blink_cnt;
    logic          r_blink_phase;
    logic [3:0]    r_snap_su;
    logic [2:0]    r_snap_st;
    logic [3:0]    r_snap_mu;
    logic [3:0]    r_snap_mt;

    logic          w_ref_wrap;
    logic [3:0]    w_digit;
    logic [3:0]    w_an;
    logic          w_blank;

    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    assign w_ref_wrap = (r_ref_cnt == REF_TOP);

    // Scan counter, digit index, and snapshot taken only on the 3->0 index wrap
    always_ff @(posedge clock) begin
        if (rst) begin
            r_ref_cnt <= '0;
            r_idx     <= 2'd0;
            r_snap_su <= 4'd0;
            r_snap_st <= 3'd0;
            r_snap_mu <= 4'd0;
            r_snap_mt <= 4'd0;
        end else if (w_ref_wrap) begin
            r_ref_cnt <= '0;
            r_idx     <= r_idx + 2'd1;
            if (r_idx == 2'd3) begin
                r_snap_su <= sec_unit;
                r_snap_st <= sec_ten;
                r_snap_mu <= min_unit;
                r_snap_mt <= min_ten;
            end
        end else begin
            r_ref_cnt <= r_ref_cnt + 1'b1;
        end
    end

    // Blink timebase; held cleared whenever adjust mode is off
    always_ff @(posedge clock) begin
        if (rst) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (adj) begin
            if (r_blink_cnt == BLINK_TOP) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end else begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end
    end

    // Digit selection and anode pattern for the current slot
    always_comb begin
        w_digit = 4'd0;
        w_an    = 4'b1111;
        case (r_idx)
            2'd0: begin w_digit = r_snap_su;          w_an = 4'b1110; end
            2'd1: begin w_digit = {1'b0, r_snap_st};  w_an = 4'b1101; end
            2'd2: begin w_digit = r_snap_mu;          w_an = 4'b1011; end
            2'd3: begin w_digit = r_snap_mt;          w_an = 4'b0111; end
            default: begin w_digit = 4'd0;            w_an = 4'b1111; end
        endcase
    end

    // idx[1] splits the display into the seconds (0,1) and minutes (2,3) fields
    assign w_blank = adj & r_blink_phase & (sel ? r_idx[1] : ~r_idx[1]);

    // Registered display drive
    always_ff @(posedge clock) begin
        if (rst) begin
            an  <= 4'b1111;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else if (w_blank) begin
            an  <= 4'b1111;
            seg <= 7'h7F;
            dp  <= 1'b1;
        end else begin
            an  <= w_an;
            seg <= seg_decode(w_digit);
            dp  <= (r_idx != 2'd2);
        end
    end

endmodule
